// File: rtl/pipeline_ctrl_pkg.sv
// Shared MIPS datapath encodings used by the pipeline controller and its bench.
package pipeline_ctrl_pkg;

  // ID-stage operand forwarding selects
  localparam logic [1:0] FWD_NO      = 2'd0;
  localparam logic [1:0] FWD_ALU_EXE = 2'd1;
  localparam logic [1:0] FWD_ALU_MEM = 2'd2;
  localparam logic [1:0] FWD_MEM     = 2'd3;

  // PC source codes decided in ID; anything other than PC_NEXT redirects fetch
  localparam logic [2:0] PC_NEXT = 3'd0;
  localparam logic [2:0] PC_JUMP = 3'd1;
  localparam logic [2:0] PC_JR   = 3'd2;
  localparam logic [2:0] PC_BEQ  = 3'd3;
  localparam logic [2:0] PC_BNE  = 3'd4;

  localparam logic [4:0] GPR_ZERO = 5'd0;

  // Per-stage control vectors, bit order {IF, ID, EXE, MEM, WB}
  localparam logic [4:0] STG_NONE    = 5'b00000;
  localparam logic [4:0] STG_ALL     = 5'b11111;
  localparam logic [4:0] STG_WB      = 5'b00001;
  localparam logic [4:0] STG_ID      = 5'b01000;
  localparam logic [4:0] STG_EXE     = 5'b00100;
  localparam logic [4:0] STG_ID_EXE  = 5'b01100;
  localparam logic [4:0] STG_EXE_DWN = 5'b00111;

  // True when a source register read in ID is produced by a downstream writer
  function automatic logic reg_match(input logic [4:0] src, input logic used,
                                     input logic [4:0] dst, input logic wen);
    return used && wen && (src != GPR_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Per-operand forwarding select: picks the youngest producer of one ID source
// register and flags a load in EXE that cannot be forwarded yet.
module pipeline_ctrl_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] src_addr,
  input  logic       src_used,
  input  logic [4:0] regw_addr_exe,
  input  logic       wb_wen_exe,
  input  logic       wb_data_src_exe,
  input  logic [4:0] regw_addr_mem,
  input  logic       wb_wen_mem,
  input  logic       wb_data_src_mem,
  output logic       load_hit,
  output logic [1:0] fwd_sel
);

  logic exe_hit;
  logic mem_hit;

  // EXE result shadows MEM result; a load in EXE has no data yet, so no select
  always_comb begin
    exe_hit  = reg_match(src_addr, src_used, regw_addr_exe, wb_wen_exe);
    mem_hit  = reg_match(src_addr, src_used, regw_addr_mem, wb_wen_mem);
    load_hit = exe_hit && wb_data_src_exe;
    fwd_sel  = FWD_NO;
    if (exe_hit) begin
      fwd_sel = wb_data_src_exe ? FWD_NO : FWD_ALU_EXE;
    end else if (mem_hit) begin
      fwd_sel = wb_data_src_mem ? FWD_MEM : FWD_ALU_MEM;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: stage
// flush/advance, operand forwarding, load-use stall, branch squash, data
// memory waits, interrupt entry and debug halt/step.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter bit DELAY_SLOT = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_is_store,
  input  logic [2:0]       pc_src_ctrl,
  input  logic [4:0]       regw_addr_exe,
  input  logic             wb_wen_exe,
  input  logic             wb_data_src_exe,
  input  logic [4:0]       regw_addr_mem,
  input  logic             wb_wen_mem,
  input  logic             wb_data_src_mem,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             ir_req,
  input  logic             debug_halt,
  input  logic             debug_step,
  output logic             if_rst,
  output logic             id_rst,
  output logic             exe_rst,
  output logic             mem_rst,
  output logic             wb_rst,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic [1:0]       exe_fwd_a_ctrl,
  output logic [1:0]       exe_fwd_b_ctrl,
  output logic             fwd_m,
  output logic             ir_ack,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALT,
    ST_IRQ
  } ctrl_state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e state;
  ctrl_state_e state_nxt;
  ctrl_state_e run_nxt;
  logic        step_q;
  logic        step_rise;

  logic        a_load;
  logic        b_load;
  logic [1:0]  a_sel;
  logic [1:0]  b_sel;
  logic        store_bypass;
  logic        load_use;
  logic        mem_stall;
  logic        branch_squash;

  logic [4:0]  run_rst;
  logic [4:0]  run_en;
  logic [4:0]  stage_rst;
  logic [4:0]  stage_en;

  pipeline_ctrl_fwd_unit u_fwd_a (
    .src_addr        (id_rs_addr),
    .src_used        (id_rs_used),
    .regw_addr_exe   (regw_addr_exe),
    .wb_wen_exe      (wb_wen_exe),
    .wb_data_src_exe (wb_data_src_exe),
    .regw_addr_mem   (regw_addr_mem),
    .wb_wen_mem      (wb_wen_mem),
    .wb_data_src_mem (wb_data_src_mem),
    .load_hit        (a_load),
    .fwd_sel         (a_sel)
  );

  pipeline_ctrl_fwd_unit u_fwd_b (
    .src_addr        (id_rt_addr),
    .src_used        (id_rt_used),
    .regw_addr_exe   (regw_addr_exe),
    .wb_wen_exe      (wb_wen_exe),
    .wb_data_src_exe (wb_data_src_exe),
    .regw_addr_mem   (regw_addr_mem),
    .wb_wen_mem      (wb_wen_mem),
    .wb_data_src_mem (wb_data_src_mem),
    .load_hit        (b_load),
    .fwd_sel         (b_sel)
  );

  // Hazard classification: a store only needs its rt as data, which can be
  // picked up from WB a cycle later, so a load feeding just the store data
  // does not stall.
  always_comb begin
    store_bypass  = b_load && id_is_store && !a_load;
    load_use      = a_load || (b_load && !store_bypass);
    mem_stall     = mem_req && !mem_ack;
    branch_squash = (pc_src_ctrl != PC_NEXT) && !DELAY_SLOT;
    step_rise     = debug_step && !step_q;
  end

  // One normal-operation cycle in priority order; halt is ignored while
  // already halted so a debug step can advance the pipe.
  always_comb begin
    run_rst = STG_NONE;
    run_en  = STG_ALL;
    run_nxt = ST_RUN;
    if (mem_stall) begin
      run_en  = STG_NONE;
      run_rst = STG_WB;
      run_nxt = ST_MEM_WAIT;
    end else if (debug_halt && (state != ST_HALT)) begin
      run_en  = STG_NONE;
      run_nxt = ST_HALT;
    end else if (ir_req && !load_use) begin
      run_nxt = ST_IRQ;
    end else if (load_use) begin
      run_en  = STG_EXE_DWN;
      run_rst = STG_EXE;
    end else if (branch_squash) begin
      run_rst = STG_ID;
    end
  end

  // Per-state stage controls, forwarding selects and next state
  always_comb begin
    stage_rst      = STG_NONE;
    stage_en       = STG_NONE;
    exe_fwd_a_ctrl = a_sel;
    exe_fwd_b_ctrl = b_sel;
    fwd_m          = store_bypass;
    ir_ack         = 1'b0;
    state_nxt      = state;
    case (state)
      ST_RUN: begin
        stage_rst = run_rst;
        stage_en  = run_en;
        state_nxt = run_nxt;
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          stage_rst = run_rst;
          stage_en  = run_en;
          state_nxt = run_nxt;
        end else begin
          stage_rst = STG_WB;
        end
      end
      ST_HALT: begin
        if (!debug_halt) begin
          stage_rst = run_rst;
          stage_en  = run_en;
          state_nxt = run_nxt;
        end else if (step_rise) begin
          stage_rst = run_rst;
          stage_en  = run_en;
          state_nxt = (run_nxt == ST_RUN) ? ST_HALT : run_nxt;
        end
      end
      ST_IRQ: begin
        stage_rst = STG_ID_EXE;
        stage_en  = STG_ALL;
        ir_ack    = 1'b1;
        state_nxt = ST_RUN;
      end
      default: begin
        stage_rst      = STG_ALL;
        exe_fwd_a_ctrl = FWD_NO;
        exe_fwd_b_ctrl = FWD_NO;
        fwd_m          = 1'b0;
        state_nxt      = ST_RUN;
      end
    endcase
  end

  assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = stage_rst;
  assign {if_en, id_en, exe_en, mem_en, wb_en}      = stage_en;

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Previous debug_step level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= debug_step;
    end
  end

  // Saturating count of fetch-stalled cycles, excluding the post-reset flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state != ST_INIT) && !stage_en[4] && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
